// File: rtl/uart_pkg.sv
// Shared UART types, limits and bit-level helpers used by the UART core.
package uart_pkg;

  localparam int UART_OVS_MIN       = 8;
  localparam int UART_DATA_BITS_MAX = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_WAIT_IDLE = 3'd0,
    RX_IDLE      = 3'd1,
    RX_START     = 3'd2,
    RX_DATA      = 3'd3,
    RX_PARITY    = 3'd4,
    RX_STOP      = 3'd5
  } rx_state_t;

  // XOR of the low nbits of data, inverted for odd parity.
  function automatic logic uart_parity(input logic [UART_DATA_BITS_MAX-1:0] data,
                                       input int nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < UART_DATA_BITS_MAX; i++) begin
      p = p ^ (data[i] & (i < nbits));
    end
    return p;
  endfunction

  function automatic logic uart_maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock oversample tick every CLK_DIV clocks.
module uart_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  assign cnt_d  = (cnt_q == CNT_LAST) ? {CW{1'b0}} : cnt_q + CNT_ONE;
  assign tick_o = tick_q;

  // Counter and registered tick, high while the counter holds CLK_DIV-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART with tick-enable timing, RX majority vote and error flags.
// Optional parity bit insertion/checking is enabled by defining UART_PARITY_EN.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_29_pll,
  input  logic                 reset,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  if (OVERSAMPLE < UART_OVS_MIN || (OVERSAMPLE % 2) != 0) begin : g_bad_ovs
    $error("uart_txrx: OVERSAMPLE must be even and >= %0d", UART_OVS_MIN);
  end
  if (DATA_BITS < 5 || DATA_BITS > UART_DATA_BITS_MAX) begin : g_bad_db
    $error("uart_txrx: DATA_BITS must be 5..%0d", UART_DATA_BITS_MAX);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_fmt
    $error("uart_txrx: STOP_BITS must be 1..2 and PARITY_ODD 0..1");
  end

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] OVS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] OVS_CENTRE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] TCNT_ONE   = TW'(1);
  localparam logic [2:0]    LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP  = 3'(STOP_BITS - 1);

  logic tick_s;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk_i (clk_29_pll),
    .rst_ni(reset),
    .tick_o(tick_s)
  );

  tx_state_t            tx_state_q, tx_state_d;
  logic                 txd_q, txd_d, tx_ready_q, tx_ready_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [TW-1:0]        tx_tcnt_q, tx_tcnt_d;
  logic [2:0]           tx_bcnt_q, tx_bcnt_d;
  logic                 tx_bit_end_s;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_bit_end_s = tick_s && (tx_tcnt_q == OVS_LAST);

  // TX next-state: txd only moves on tick clocks; the start edge waits for the first tick.
  always_comb begin
    tx_state_d = tx_state_q;
    txd_d      = txd_q;
    tx_shift_d = tx_shift_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_tcnt_d  = tick_s ? ((tx_tcnt_q == OVS_LAST) ? {TW{1'b0}} : tx_tcnt_q + TCNT_ONE) : tx_tcnt_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          tx_shift_d = tx_data;
          tx_state_d = TX_START;
`ifdef UART_PARITY_EN
          tx_par_d   = uart_parity(UART_DATA_BITS_MAX'(tx_data), DATA_BITS, PARITY_ODD != 0);
`endif
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tick_s && txd_q) begin
          txd_d     = 1'b0;
          tx_tcnt_d = {TW{1'b0}};
        end else if (tx_bit_end_s) begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bcnt_d  = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_bit_end_s && tx_bcnt_q == LAST_DATA) begin
          tx_bcnt_d  = 3'd0;
`ifdef UART_PARITY_EN
          txd_d      = tx_par_q;
          tx_state_d = TX_PARITY;
`else
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
`endif
        end else if (tx_bit_end_s) begin
          tx_bcnt_d  = tx_bcnt_q + 3'd1;
          txd_d      = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end else begin
          tx_state_d = TX_DATA;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_end_s) begin
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_state_d = TX_PARITY;
        end
      end
`endif
      TX_STOP: begin
        if (tx_bit_end_s && tx_bcnt_q == LAST_STOP) begin
          tx_state_d = TX_IDLE;
        end else if (tx_bit_end_s) begin
          tx_bcnt_d = tx_bcnt_q + 3'd1;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  // TX state registers; reset drives the line idle at once.
  always_ff @(posedge clk_29_pll or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_shift_q <= {DATA_BITS{1'b0}};
      tx_tcnt_q  <= {TW{1'b0}};
      tx_bcnt_q  <= 3'd0;
    end else begin
      tx_state_q <= tx_state_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
      tx_shift_q <= tx_shift_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
    end
  end

  rx_state_t            rx_state_q, rx_state_d;
  logic                 rxd_s1_q, rxd_s2_q;
  logic [2:0]           rx_samp_q, rx_samp_d;
  logic [TW-1:0]        rx_tcnt_q, rx_tcnt_d;
  logic [2:0]           rx_bcnt_q, rx_bcnt_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, framing_err_q, framing_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_vote_s, rx_centre_s, rx_done_s;
`ifdef UART_PARITY_EN
  logic                 rx_perr_q, rx_perr_d, parity_err_q, parity_err_d;
`endif

  assign rx_samp_d   = tick_s ? {rx_samp_q[1:0], rxd_s2_q} : rx_samp_q;
  assign rx_vote_s   = uart_maj3({rx_samp_q[1:0], rxd_s2_q});
  assign rx_centre_s = tick_s && (rx_tcnt_q == OVS_CENTRE);

  // RX next-state: the detecting tick is tick 0 of the start bit; votes happen at bit centres.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_done_s  = 1'b0;
    rx_tcnt_d  = tick_s ? ((rx_tcnt_q == OVS_LAST) ? {TW{1'b0}} : rx_tcnt_q + TCNT_ONE) : rx_tcnt_q;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      RX_WAIT_IDLE: rx_state_d = (tick_s && rxd_s2_q) ? RX_IDLE : RX_WAIT_IDLE;
      RX_IDLE: begin
        if (tick_s && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = TCNT_ONE;
        end else begin
          rx_tcnt_d  = {TW{1'b0}};
        end
      end
      RX_START: begin
        if (rx_centre_s) begin
          rx_state_d = rx_vote_s ? RX_IDLE : RX_DATA;
          rx_bcnt_d  = 3'd0;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_centre_s) begin
          rx_shift_d = {rx_vote_s, rx_shift_q[DATA_BITS-1:1]};
          rx_bcnt_d  = (rx_bcnt_q == LAST_DATA) ? 3'd0 : rx_bcnt_q + 3'd1;
`ifdef UART_PARITY_EN
          rx_state_d = (rx_bcnt_q == LAST_DATA) ? RX_PARITY : RX_DATA;
`else
          rx_state_d = (rx_bcnt_q == LAST_DATA) ? RX_STOP : RX_DATA;
`endif
        end else begin
          rx_state_d = RX_DATA;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_centre_s) begin
          rx_perr_d  = rx_vote_s ^ uart_parity(UART_DATA_BITS_MAX'(rx_shift_q), DATA_BITS, PARITY_ODD != 0);
          rx_state_d = RX_STOP;
        end else begin
          rx_state_d = RX_PARITY;
        end
      end
`endif
      RX_STOP: begin
        if (rx_centre_s) begin
          rx_done_s  = 1'b1;
          rx_state_d = rx_vote_s ? RX_IDLE : RX_WAIT_IDLE;
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      default: rx_state_d = RX_WAIT_IDLE;
    endcase
  end

  // Completed frames overwrite the held byte; an unread overwrite marks overrun.
  always_comb begin
    rx_data_d     = rx_data_q;
    framing_err_d = framing_err_q;
    overrun_d     = (rx_done_s && rx_valid_q && !rx_ready) || (overrun_q && !err_clr);
`ifdef UART_PARITY_EN
    parity_err_d  = parity_err_q;
`endif
    if (rx_done_s) begin
      rx_data_d     = rx_shift_q;
      framing_err_d = !rx_vote_s;
      rx_valid_d    = 1'b1;
`ifdef UART_PARITY_EN
      parity_err_d  = rx_perr_q;
`endif
    end else begin
      rx_valid_d    = rx_valid_q && !rx_ready;
    end
  end

  // RX state, synchroniser and output registers.
  always_ff @(posedge clk_29_pll or negedge reset) begin
    if (!reset) begin
      rxd_s1_q      <= 1'b1;
      rxd_s2_q      <= 1'b1;
      rx_samp_q     <= 3'b111;
      rx_state_q    <= RX_WAIT_IDLE;
      rx_tcnt_q     <= {TW{1'b0}};
      rx_bcnt_q     <= 3'd0;
      rx_shift_q    <= {DATA_BITS{1'b0}};
      rx_data_q     <= {DATA_BITS{1'b0}};
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rxd_s1_q      <= rxd;
      rxd_s2_q      <= rxd_s1_q;
      rx_samp_q     <= rx_samp_d;
      rx_state_q    <= rx_state_d;
      rx_tcnt_q     <= rx_tcnt_d;
      rx_bcnt_q     <= rx_bcnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef UART_PARITY_EN
  // Parity bit latched at TX handshake and RX parity result held for the frame.
  always_ff @(posedge clk_29_pll or negedge reset) begin
    if (!reset) begin
      tx_par_q     <= 1'b0;
      rx_perr_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      tx_par_q     <= tx_par_d;
      rx_perr_q    <= rx_perr_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign txd         = txd_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Directed scoreboard bench for uart_txrx (default parameters, optional UART_PARITY_EN).
module tb_uart_txrx;

  localparam int CLK_DIV = 16;
  localparam int OVS     = 16;
  localparam int BITCLK  = CLK_DIV * OVS;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
`else
  localparam bit PAR_EN  = 1'b0;
`endif
  localparam int NBITS   = 10 + int'(PAR_EN);

  logic       clk = 1'b0;
  logic       reset, rxd, txd, tx_valid, tx_ready, rx_valid, rx_ready;
  logic       framing_err, parity_err, overrun, err_clr;
  logic [7:0] tx_data, rx_data;
  logic       loop_en, rxd_drv;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_txrx dut (
    .clk_29_pll (clk),
    .reset      (reset),
    .rxd        (rxd),
    .txd        (txd),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .framing_err(framing_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    sb.push_back(e);
  endtask

  task automatic send_tx(input logic [7:0] d);
    int k;
    k = 0;
    while (!tx_ready && k < 2 * NBITS * BITCLK) begin
      @(negedge clk);
      k++;
    end
    chk("tx_ready_before_send", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_after_handshake", tx_ready, 0);
  endtask

  task automatic ser_bit(input logic b);
    rxd_drv = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic ser_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
    ser_bit(1'b0);
    for (int i = 0; i < 8; i++) ser_bit(d[i]);
    if (PAR_EN) ser_bit((^d) ^ par_bad);
    ser_bit(stop_b);
  endtask

  task automatic check_rx(input string tag, input logic exp_ovr, input bit ack);
    exp_t e;
    int   k;
    k = 0;
    while (!rx_valid && k < 2 * NBITS * BITCLK) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rx_valid"}, rx_valid, 1);
    e = sb.pop_front();
    chk({tag, "_rx_data"}, rx_data, e.d);
    chk({tag, "_framing_err"}, framing_err, e.fe);
    chk({tag, "_parity_err"}, parity_err, e.pe);
    chk({tag, "_overrun"}, overrun, exp_ovr);
    if (ack) begin
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk({tag, "_rx_valid_cleared"}, rx_valid, 0);
    end
  endtask

  task automatic tx_frame_check(input logic [7:0] d);
    int k, el;
    send_tx(d);
    k = 0;
    while (txd && k < 2 * CLK_DIV) begin
      @(negedge clk);
      k++;
    end
    chk("tx_start_edge_within_tick", txd, 0);
    el = BITCLK / 2;
    repeat (BITCLK / 2) @(negedge clk);
    chk("tx_start_bit", txd, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BITCLK) @(negedge clk);
      el += BITCLK;
      chk($sformatf("tx_data_bit%0d", i), txd, d[i]);
    end
`ifdef UART_PARITY_EN
    repeat (BITCLK) @(negedge clk);
    el += BITCLK;
    chk("tx_parity_bit", txd, ^d);
`endif
    repeat (BITCLK) @(negedge clk);
    el += BITCLK;
    chk("tx_stop_bit", txd, 1);
    chk("tx_ready_low_in_frame", tx_ready, 0);
    while (!tx_ready && el < NBITS * BITCLK + 4 * CLK_DIV) begin
      @(negedge clk);
      el++;
    end
    chk("tx_frame_length", el, NBITS * BITCLK);
  endtask

  initial begin
    int spur;
    reset    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    loop_en  = 1'b0;
    rxd_drv  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_framing_err", framing_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // 1: TX waveform and frame length
    tx_frame_check(8'hA5);

    // 2: loopback with rx_ready held high
    loop_en  = 1'b1;
    rx_ready = 1'b1;
    push_exp(8'h00, 1'b0, 1'b0); send_tx(8'h00); check_rx("loop00", 1'b0, 1'b0);
    push_exp(8'hFF, 1'b0, 1'b0); send_tx(8'hFF); check_rx("loopFF", 1'b0, 1'b0);
    push_exp(8'h55, 1'b0, 1'b0); send_tx(8'h55); check_rx("loop55", 1'b0, 1'b0);
    repeat (2 * BITCLK) @(negedge clk);
    loop_en  = 1'b0;
    rx_ready = 1'b0;

    // 3: short start glitch is rejected, then a clean frame
    rxd_drv = 1'b0;
    repeat (4 * CLK_DIV) @(negedge clk);
    rxd_drv = 1'b1;
    spur = 0;
    repeat (3 * BITCLK) begin
      @(negedge clk);
      if (rx_valid) spur++;
    end
    chk("glitch_no_rx_valid", spur, 0);
    push_exp(8'h3C, 1'b0, 1'b0);
    ser_frame(8'h3C, 1'b1, 1'b0);
    check_rx("after_glitch", 1'b0, 1'b1);

    // 4: stop bit low then break
    push_exp(8'h3C, 1'b1, 1'b0);
    ser_frame(8'h3C, 1'b0, 1'b0);
    check_rx("break", 1'b0, 1'b1);
    spur = 0;
    repeat (2 * BITCLK) begin
      @(negedge clk);
      if (rx_valid) spur++;
    end
    chk("break_no_spurious", spur, 0);
    ser_bit(1'b1);
    push_exp(8'h5A, 1'b0, 1'b0);
    ser_frame(8'h5A, 1'b1, 1'b0);
    check_rx("after_break", 1'b0, 1'b1);

    // 5: overrun, err_clr and read
    push_exp(8'h11, 1'b0, 1'b0);
    ser_frame(8'h11, 1'b1, 1'b0);
    check_rx("ovr_first", 1'b0, 1'b0);
    push_exp(8'h22, 1'b0, 1'b0);
    ser_frame(8'h22, 1'b1, 1'b0);
    check_rx("ovr_second", 1'b1, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_overrun", overrun, 0);
    chk("err_clr_keeps_valid", rx_valid, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("read_clears_valid", rx_valid, 0);

`ifdef UART_PARITY_EN
    // 6: parity bit on TX and parity error on RX
    tx_frame_check(8'h07);
    push_exp(8'h07, 1'b0, 1'b1);
    ser_frame(8'h07, 1'b1, 1'b1);
    check_rx("bad_parity", 1'b0, 1'b1);
`endif

    // Reset in the middle of a transmitted frame
    send_tx(8'h00);
    repeat (600) @(negedge clk);
    chk("mid_frame_txd_low", txd, 0);
    reset = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1);
    chk("async_reset_tx_ready", tx_ready, 1);
    chk("async_reset_rx_valid", rx_valid, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    loop_en  = 1'b1;
    rx_ready = 1'b1;
    push_exp(8'hC3, 1'b0, 1'b0);
    send_tx(8'hC3);
    check_rx("after_reset", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
